// File: rtl/keypad_emulator.sv
// keypad_emulator
// Emulates one switch of a 4x4 matrix keypad for a keypad scanner under test.
// A press command walks through press bounce, a stable hold, release bounce
// and a quiet gap, then pulses done. While the emulated switch is closed, the
// row of the latched key is pulled low whenever the scanner drives that key's
// column low. Row sense lags column drive by one registered cycle.

module keypad_emulator #(
  parameter int BOUNCE_TOGGLES = 2,  // bounce pulses per press/release edge (0 = none)
  parameter int BOUNCE_PERIOD  = 4,  // cycles each bounce level is held (>= 1)
  parameter int GAP_CYCLES     = 8   // quiet cycles after release before done (>= 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  input  logic        abort,
  output logic        busy,
  output logic        contact,
  output logic        done
);

  // Number of bounce levels walked through on each edge of the press.
  localparam int LEVELS = 2 * BOUNCE_TOGGLES;

  // Level index width; at least one bit so the register always exists.
  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  // Phase counter must cover a full 16-bit hold as well as both parameters,
  // so no phase can wrap before it terminates.
  localparam int PW  = $clog2(BOUNCE_PERIOD + 1);
  localparam int GW  = $clog2(GAP_CYCLES + 1);
  localparam int PGW = (PW > GW) ? PW : GW;
  localparam int CW  = (PGW > 16) ? PGW : 16;

  // Counters load "cycles - 1" and the phase ends when they reach zero.
  localparam logic [CW-1:0] BP_LOAD  = CW'(BOUNCE_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
  localparam logic [LW-1:0] LAST_LVL = LW'((LEVELS > 0) ? (LEVELS - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_BOUNCE_PRESS   = 3'd1,
    S_HOLD           = 3'd2,
    S_BOUNCE_RELEASE = 3'd3,
    S_GAP            = 3'd4
  } state_t;

  state_t        state_reg,   state_next;
  logic [CW-1:0] cnt_reg,     cnt_next;
  logic [LW-1:0] lvl_reg,     lvl_next;
  logic [3:0]    key_reg,     key_next;
  logic [15:0]   hold_reg,    hold_next;
  logic          contact_reg, contact_next;
  logic          done_reg,    done_next;
  logic [3:0]    row_reg,     row_next;

  // Effective hold length of the incoming command: zero is stretched to one.
  logic [15:0]   cmd_hold_eff;
  logic [CW-1:0] cmd_hold_load;
  logic [CW-1:0] hold_load;
  logic          accept;

  // Key decode for the row/column matrix: index i maps to bit 3-i, i.e. ~i.
  logic [1:0]    row_bit;
  logic [1:0]    col_bit;
  logic          col_hit;

  assign cmd_hold_eff  = (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
  assign cmd_hold_load = CW'(cmd_hold_eff) - CW'(1);
  assign hold_load     = CW'(hold_reg) - CW'(1);

  assign cmd_ready = (state_reg == S_IDLE) && !abort;
  assign busy      = (state_reg != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  assign contact = contact_reg;
  assign done    = done_reg;
  assign row     = row_reg;

  assign row_bit = ~key_reg[3:2];
  assign col_bit = ~key_reg[1:0];
  assign col_hit = ~col[col_bit];

  // Per-row sense: only the latched key's row can be pulled low, and only
  // while the switch is closed and its column is being driven.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign row_next[gi] = ~(contact_reg && col_hit && (row_bit == 2'(gi)));
    end
  endgenerate

  // State, counters, latched command and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      lvl_reg     <= '0;
      key_reg     <= '0;
      hold_reg    <= 16'd1;
      contact_reg <= 1'b0;
      done_reg    <= 1'b0;
      row_reg     <= 4'b1111;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      lvl_reg     <= lvl_next;
      key_reg     <= key_next;
      hold_reg    <= hold_next;
      contact_reg <= contact_next;
      done_reg    <= done_next;
      row_reg     <= row_next;
    end
  end

  // Next-state logic: each phase counts down its level, then hands over.
  // contact_next is the level the switch shows during the coming cycle.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    lvl_next     = lvl_reg;
    key_next     = key_reg;
    hold_next    = hold_reg;
    contact_next = contact_reg;
    done_next    = 1'b0;

    if (state_reg != S_IDLE && abort) begin
      // Abandon the press immediately; the switch opens, no done.
      state_next   = S_IDLE;
      cnt_next     = '0;
      lvl_next     = '0;
      contact_next = 1'b0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          contact_next = 1'b0;
          if (accept) begin
            key_next     = cmd_key;
            hold_next    = cmd_hold_eff;
            lvl_next     = '0;
            contact_next = 1'b1;
            if (LEVELS > 0) begin
              state_next = S_BOUNCE_PRESS;
              cnt_next   = BP_LOAD;
            end else begin
              state_next = S_HOLD;
              cnt_next   = cmd_hold_load;
            end
          end
        end

        S_BOUNCE_PRESS: begin
          // Levels alternate 1,0,1,0...; level l shows ~l[0].
          if (cnt_reg == '0) begin
            if (lvl_reg == LAST_LVL) begin
              state_next   = S_HOLD;
              cnt_next     = hold_load;
              lvl_next     = '0;
              contact_next = 1'b1;
            end else begin
              lvl_next     = lvl_reg + LW'(1);
              cnt_next     = BP_LOAD;
              contact_next = lvl_reg[0];
            end
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end

        S_HOLD: begin
          if (cnt_reg == '0) begin
            contact_next = 1'b0;
            lvl_next     = '0;
            if (LEVELS > 0) begin
              state_next = S_BOUNCE_RELEASE;
              cnt_next   = BP_LOAD;
            end else begin
              state_next = S_GAP;
              cnt_next   = GAP_LOAD;
            end
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end

        S_BOUNCE_RELEASE: begin
          // Levels alternate 0,1,0,1...; level l shows l[0].
          if (cnt_reg == '0) begin
            if (lvl_reg == LAST_LVL) begin
              state_next   = S_GAP;
              cnt_next     = GAP_LOAD;
              lvl_next     = '0;
              contact_next = 1'b0;
            end else begin
              lvl_next     = lvl_reg + LW'(1);
              cnt_next     = BP_LOAD;
              contact_next = ~lvl_reg[0];
            end
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end

        S_GAP: begin
          contact_next = 1'b0;
          if (cnt_reg == '0) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            done_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end

        default: begin
          state_next   = S_IDLE;
          cnt_next     = '0;
          lvl_next     = '0;
          contact_next = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator
// Directed bench for keypad_emulator: one instance with default bounce
// settings and one with bounce disabled. Outputs are sampled on the falling
// edge; "window k" is the clock cycle that ends with the k-th rising edge
// after the accepting edge.

module tb_keypad_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  col;
  logic        cmd_valid;
  logic        cmd_valid0;
  logic [3:0]  cmd_key;
  logic [15:0] cmd_hold;
  logic        abort;

  logic [3:0]  row,  row0;
  logic        cmd_ready, cmd_ready0;
  logic        busy, busy0;
  logic        contact, contact0;
  logic        done, done0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  keypad_emulator dut (
    .clk(clk), .reset(reset), .col(col), .row(row),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
    .cmd_hold(cmd_hold), .abort(abort), .busy(busy),
    .contact(contact), .done(done)
  );

  keypad_emulator #(.BOUNCE_TOGGLES(0), .BOUNCE_PERIOD(4), .GAP_CYCLES(8)) dut0 (
    .clk(clk), .reset(reset), .col(col), .row(row0),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_key(cmd_key),
    .cmd_hold(cmd_hold), .abort(abort), .busy(busy0),
    .contact(contact0), .done(done0)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Hand-derived contact waveform for defaults with hold 10:
  // 1111 0000 1111 0000 | 1 x10 | 0000 1111 0000 1111 | 0 x8
  function automatic logic exp_contact(input int k);
    if (k >= 1 && k <= 16)  return (((k - 1) / 4) % 2) == 0;
    if (k >= 17 && k <= 26) return 1'b1;
    if (k >= 27 && k <= 42) return (((k - 27) / 4) % 2) == 1;
    return 1'b0;
  endfunction

  logic prev_c;
  logic prev_busy;
  int   k;
  bit   seen;

  initial begin
    reset = 1'b1; col = 4'b1111; cmd_valid = 1'b0; cmd_valid0 = 1'b0;
    cmd_key = 4'd0; cmd_hold = 16'd0; abort = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_row", row, 4'b1111);
    check_val("rst_contact", contact, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_ready", cmd_ready, 1);
    $display("txn reset: state checked");

    // Full default sequence, key 0, hold 10, col 0111 held
    col = 4'b0111; cmd_key = 4'd0; cmd_hold = 16'd10; cmd_valid = 1'b1;
    prev_c = 1'b0;
    for (int w = 1; w <= 52; w++) begin
      @(negedge clk);
      if (w == 1) cmd_valid = 1'b0;
      check_val($sformatf("seq_contact_w%0d", w), contact, exp_contact(w));
      check_val($sformatf("seq_row_w%0d", w), row, prev_c ? 4'b0111 : 4'b1111);
      check_val($sformatf("seq_done_w%0d", w), done, (w == 51));
      check_val($sformatf("seq_busy_w%0d", w), busy, (w <= 50));
      prev_c = contact;
    end
    $display("txn press key=0 hold=10: full sequence checked");

    // Other key only sensed on its own column; then abort 3 cycles into HOLD
    col = 4'b0111; cmd_key = 4'b0110; cmd_hold = 16'd20; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (18) @(negedge clk);  // window 19, third HOLD cycle
    check_val("key6_contact", contact, 1);
    check_val("key6_row_wrong_col", row, 4'b1111);
    col = 4'b1101;
    @(negedge clk);              // window 20
    check_val("key6_row_own_col", row, 4'b1011);
    abort = 1'b1;
    @(negedge clk);              // window 21
    check_val("abort_contact", contact, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    abort = 1'b0;
    #1;
    check_val("abort_ready", cmd_ready, 1);
    @(negedge clk);              // window 22
    check_val("abort_row", row, 4'b1111);
    check_val("abort_done_late", done, 0);
    $display("txn press key=6 hold=20: aborted in HOLD");

    // Abort together with cmd_valid in IDLE: not accepted
    abort = 1'b1; cmd_valid = 1'b1;
    #1;
    check_val("abortidle_ready", cmd_ready, 0);
    @(negedge clk);
    check_val("abortidle_busy", busy, 0);
    check_val("abortidle_contact", contact, 0);
    abort = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check_val("abortidle_busy2", busy, 0);
    $display("txn abort+valid in idle: ignored");

    // No-bounce instance, hold 0: contact one cycle, gap 8, done at window 10
    col = 4'b0111; cmd_key = 4'd0; cmd_hold = 16'd0; cmd_valid0 = 1'b1;
    for (int w = 1; w <= 11; w++) begin
      @(negedge clk);
      if (w == 1) cmd_valid0 = 1'b0;
      check_val($sformatf("nb_contact_w%0d", w), contact0, (w == 1));
      check_val($sformatf("nb_done_w%0d", w), done0, (w == 10));
      check_val($sformatf("nb_busy_w%0d", w), busy0, (w <= 9));
      if (w == 2) check_val("nb_row_w2", row0, 4'b0111);
    end
    $display("txn no-bounce press hold=0: checked");

    // Reset in the middle of BOUNCE_RELEASE
    col = 4'b0111; cmd_key = 4'd0; cmd_hold = 16'd2; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_val("mid_contact_w1", contact, 1);
    repeat (21) @(negedge clk);  // window 22, release bounce
    check_val("mid_busy_w22", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_val("midrst_row", row, 4'b1111);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_done", done, 0);
    check_val("midrst_contact", contact, 0);
    $display("txn reset during release bounce: checked");

    // New command after reset, cmd_valid held across two commands
    reset = 1'b0; cmd_valid = 1'b1; cmd_hold = 16'd2;
    @(negedge clk);
    check_val("post_rst_accept", contact, 1);
    k = 1; seen = 1'b0; prev_busy = busy;
    for (int w = 2; w <= 100; w++) begin
      @(negedge clk);
      if (done) begin
        k = w; seen = 1'b1;
        break;
      end
      prev_busy = busy;
    end
    check_val("b2b_done_seen", seen, 1);
    check_val("b2b_done_window", k, 43);
    check_val("b2b_busy_before_done", prev_busy, 1);
    check_val("b2b_busy_at_done", busy, 0);
    check_val("b2b_contact_at_done", contact, 0);
    @(negedge clk);
    check_val("b2b_second_contact", contact, 1);
    check_val("b2b_second_busy", busy, 1);
    cmd_valid = 1'b0;
    $display("txn back-to-back press: second accepted after done");

    seen = 1'b0;
    for (int w = 2; w <= 100; w++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("b2b_second_done", seen, 1);
    @(negedge clk);
    check_val("final_idle_busy", busy, 0);
    $display("txn second press: completed");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
